// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: scan states, key code layout and press-map indexing.
// Pure declarations, no logic, no flow control.
package keypad_pkg;

    localparam int KP_COLS = 4;
    localparam int KP_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SETTLE,
        SAMPLE
    } scan_state_t;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_code_t;

    // Flat press-map bit for a key; matches the key_code bit layout.
    function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/kp_press_select.sv
// Picks the lowest newly pressed row of one column and returns the column's updated press-map slice.
// Combinational, zero latency; reports only when the output register is free, otherwise defers the press.
module kp_press_select
    import keypad_pkg::*;
(
    input  logic [KP_ROWS-1:0] row_edge,
    input  logic [KP_ROWS-1:0] map_col,
    input  logic               out_free,
    output logic [1:0]         sel_row,
    output logic               report,
    output logic [KP_ROWS-1:0] map_next
);

    logic [KP_ROWS-1:0] new_press;
    logic               found;

    always_comb begin
        new_press = row_edge & ~map_col;
        sel_row   = 2'd0;
        found     = 1'b0;
        for (int r = KP_ROWS - 1; r >= 0; r--) begin
            if (new_press[r]) begin
                sel_row = 2'(r);
                found   = 1'b1;
            end
        end
        report = found & out_free;

        // Released rows drop out; unreported presses stay clear so a later scan retries them.
        map_next = map_col & row_edge;
        if (report) begin
            map_next[sel_row] = 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 keypad column by column and emits one key code per new press on a valid/ready port.
// Column period SETTLE_CYCLES+2; a press appears one cycle after its column's sample; key_ready low holds the code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_COLS      = 4,
    parameter int NUM_ROWS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] row_edge,
    output logic [NUM_COLS-1:0] col_drive,
    output logic                filt_en,
    output logic [1:0]          col_idx,
    output logic                key_valid,
    output logic [3:0]          key_code,
    input  logic                key_ready
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_t  state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [1:0]   col_q, col_d;
    logic [15:0]  map_q, map_d;
    logic         kv_q, kv_d;
    key_code_t    code_q, code_d;

    logic [KP_ROWS-1:0] map_col;
    logic [KP_ROWS-1:0] map_next;
    logic [1:0]         sel_row;
    logic               report;
    logic               out_free;
    logic               sample_go;
    logic               driving;

    assign out_free  = ~kv_q | key_ready;
    assign sample_go = (state_q == SAMPLE) & scan_en;

    always_comb begin
        map_col = '0;
        for (int r = 0; r < KP_ROWS; r++) begin
            map_col[r] = map_q[key_index(col_q, 2'(r))];
        end
    end

    kp_press_select u_select (
        .row_edge (row_edge),
        .map_col  (map_col),
        .out_free (out_free),
        .sel_row  (sel_row),
        .report   (report),
        .map_next (map_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        map_d   = map_q;
        kv_d    = kv_q;
        code_d  = code_q;

        if (kv_q && key_ready) begin
            kv_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = SETTLE;
                cnt_d   = 4'd0;
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = GAP;
                // A sample cut short by scan_en is abandoned; resume rescans the same column.
                if (sample_go) begin
                    col_d = col_q + 2'd1;
                    for (int r = 0; r < KP_ROWS; r++) begin
                        map_d[key_index(col_q, 2'(r))] = map_next[r];
                    end
                    if (report) begin
                        kv_d   = 1'b1;
                        code_d = '{col: col_q, row: sel_row};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!scan_en) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            col_q   <= 2'd0;
            map_q   <= 16'h0;
            kv_q    <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            map_q   <= map_d;
            kv_q    <= kv_d;
            code_q  <= code_d;
        end
    end

    assign driving = (state_q == SETTLE) || (state_q == SAMPLE);

    always_comb begin
        col_drive = '0;
        if (driving) begin
            col_drive[col_q] = 1'b1;
        end
    end

    assign filt_en   = driving;
    assign col_idx   = col_q;
    assign key_valid = kv_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan-sequence table, press-scenario table and hand-written corner cases.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_en;
    logic [3:0] row_edge;
    logic       key_ready;
    logic [3:0] col_drive;
    logic       filt_en;
    logic [1:0] col_idx;
    logic       key_valid;
    logic [3:0] key_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SETTLE_CYCLES (4),
        .NUM_COLS      (4),
        .NUM_ROWS      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .row_edge  (row_edge),
        .col_drive (col_drive),
        .filt_en   (filt_en),
        .col_idx   (col_idx),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready)
    );

    typedef struct {
        logic       scan_en;
        logic [3:0] drive;
        logic       filt;
        logic [1:0] idx;
        logic       kv;
    } scan_vec_t;

    typedef struct {
        string      name;
        logic [15:0] keys;
        int         scans;
        int         exp_n;
        logic [3:0] exp_first;
        logic [3:0] exp_last;
    } press_vec_t;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] keys       = 16'h0;
    logic [3:0]  codes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Keypad model: a held key closes its row while its column is driven and the filter is enabled.
    task automatic drive_rows();
        logic [3:0] r_v;
        r_v = '0;
        for (int r = 0; r < 4; r++) begin
            r_v[r] = filt_en & keys[{col_idx, r[1:0]}];
        end
        row_edge = r_v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_rows();
    endtask

    task automatic run_collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (key_valid === 1'b1 && key_ready === 1'b1) begin
                codes.push_back(key_code);
            end
            step();
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        i = 0;
        while (key_valid !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        check(name, key_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        scan_vec_t  scan_tbl[25];
        press_vec_t press_tbl[8];
        logic       stable;
        logic [3:0] c0, c1;
        int         i;

        for (int n = 1; n <= 25; n++) begin
            int ph, col;
            ph  = (n - 1) % 6;
            col = ((n - 1) / 6) % 4;
            scan_tbl[n-1].scan_en = 1'b1;
            scan_tbl[n-1].drive   = (ph == 0) ? 4'b0000 : 4'(1 << col);
            scan_tbl[n-1].filt    = (ph != 0);
            scan_tbl[n-1].idx     = 2'(col);
            scan_tbl[n-1].kv      = 1'b0;
        end

        press_tbl[0] = '{"hold_2_2",   16'h0400, 10, 1, 4'hA, 4'hA};
        press_tbl[1] = '{"release_a",  16'h0000,  1, 0, 4'h0, 4'h0};
        press_tbl[2] = '{"press_1_0",  16'h0010,  3, 1, 4'h4, 4'h4};
        press_tbl[3] = '{"release_b",  16'h0000,  1, 0, 4'h0, 4'h0};
        press_tbl[4] = '{"repress_1_0",16'h0010,  2, 1, 4'h4, 4'h4};
        press_tbl[5] = '{"release_c",  16'h0000,  1, 0, 4'h0, 4'h0};
        press_tbl[6] = '{"col3_two",   16'h9000,  3, 2, 4'hC, 4'hF};
        press_tbl[7] = '{"release_d",  16'h0000,  1, 0, 4'h0, 4'h0};

        rst       = 1'b0;
        scan_en   = 1'b0;
        key_ready = 1'b0;
        row_edge  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset col_drive", col_drive, 4'h0);
        check("reset filt_en",   filt_en,   1'b0);
        check("reset col_idx",   col_idx,   2'd0);
        check("reset key_valid", key_valid, 1'b0);
        check("reset key_code",  key_code,  4'h0);

        rst       = 1'b1;
        key_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            scan_en = scan_tbl[k].scan_en;
            step();
            check($sformatf("scan[%0d] {drive,filt,idx,kv}", k),
                  {col_drive, filt_en, col_idx, key_valid},
                  {scan_tbl[k].drive, scan_tbl[k].filt, scan_tbl[k].idx, scan_tbl[k].kv});
        end

        for (int k = 0; k < 8; k++) begin
            codes.delete();
            keys = press_tbl[k].keys;
            drive_rows();
            run_collect(press_tbl[k].scans * 24);
            check({press_tbl[k].name, " reports"}, codes.size(), press_tbl[k].exp_n);
            if (press_tbl[k].exp_n > 0) begin
                c0 = (codes.size() > 0) ? codes[0] : 4'hx;
                c1 = (codes.size() > 0) ? codes[codes.size()-1] : 4'hx;
                check({press_tbl[k].name, " first code"}, c0, press_tbl[k].exp_first);
                check({press_tbl[k].name, " last code"},  c1, press_tbl[k].exp_last);
            end
        end

        // Backpressure: pending 4'h5 must hold while a new press at {3,3} waits its turn.
        key_ready = 1'b0;
        keys      = 16'h0020;
        drive_rows();
        wait_valid("bp first valid", 30);
        check("bp first code", key_code, 4'h5);
        keys = 16'h8020;
        drive_rows();
        stable = 1'b1;
        for (int k = 0; k < 48; k++) begin
            step();
            stable &= (key_valid === 1'b1) && (key_code === 4'h5);
        end
        check("bp held stable", stable, 1'b1);
        key_ready = 1'b1;
        codes.delete();
        run_collect(30);
        c0 = (codes.size() > 0) ? codes[0] : 4'hx;
        c1 = (codes.size() > 1) ? codes[1] : 4'hx;
        check("bp reports after ready", codes.size(), 2);
        check("bp accepted code", c0, 4'h5);
        check("bp deferred code", c1, 4'hF);
        keys = 16'h0;
        drive_rows();
        run_collect(24);

        // scan_en drop during column 1 settle, then reset in the middle of a sample.
        key_ready = 1'b0;
        keys      = 16'h0002;
        drive_rows();
        wait_valid("drop pending valid", 30);
        check("drop pending code", key_code, 4'h1);
        i = 0;
        while (!(col_idx == 2'd1 && col_drive != 4'h0) && i < 30) begin
            step();
            i++;
        end
        check("drop at col1 settle", {col_idx, col_drive}, {2'd1, 4'b0010});
        scan_en = 1'b0;
        step();
        check("drop {drive,filt}", {col_drive, filt_en}, {4'h0, 1'b0});
        check("drop kept {idx,kv,code}", {col_idx, key_valid, key_code}, {2'd1, 1'b1, 4'h1});
        stable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            stable &= (col_drive === 4'h0) && (filt_en === 1'b0);
        end
        check("drop idle quiet", stable, 1'b1);
        scan_en = 1'b1;
        step();
        check("resume gap drive", col_drive, 4'h0);
        step();
        check("resume first drive", {col_drive, filt_en}, {4'b0010, 1'b1});
        repeat (4) step();
        check("sample still driven", {col_drive, filt_en}, {4'b0010, 1'b1});
        keys = 16'h0;
        rst  = 1'b0;
        #2;
        check("async reset outputs",
              {col_drive, filt_en, col_idx, key_valid, key_code},
              {4'h0, 1'b0, 2'd0, 1'b0, 4'h0});
        #2;
        rst = 1'b1;
        step();
        step();
        check("post reset col0", {col_drive, col_idx}, {4'b0001, 2'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
